// File: rtl/systolic_fir_array_pkg.sv
// ----------------------------------------------------------------------------
// fir_pkg
//   Shared definitions for the systolic FIR array:
//     - fir_state_t : coefficient-load FSM states (RUN, LOAD)
//     - acc_width() : full-precision accumulator width for a given geometry
//     - round_sat() : round-half-up, arithmetic right shift and saturation of
//                     an accumulator value to a signed output width
// ----------------------------------------------------------------------------
package fir_pkg;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_LOAD = 1'b1
    } fir_state_t;

    // Working width of the round/saturate helper. Accumulators are
    // sign-extended into this width, so ACC_W must not exceed it.
    localparam int RS_W = 64;

    // DATA_W*COEF_W product plus clog2(TAPS) growth bits for the sum of
    // TAPS products: no overflow is possible anywhere in the chain.
    function automatic int acc_width(input int data_w, input int coef_w, input int taps);
        return data_w + coef_w + $clog2(taps);
    endfunction

    // (acc + 2^(shift-1)) >>> shift, then clamp to the signed out_w range.
    // sat reports whether the clamp was applied.
    function automatic logic signed [RS_W-1:0] round_sat(
        input  logic signed [RS_W-1:0] acc,
        input  int                     shift,
        input  int                     out_w,
        output logic                   sat
    );
        logic signed [RS_W-1:0] v;
        logic signed [RS_W-1:0] hi;
        logic signed [RS_W-1:0] lo;
        v  = acc;
        if (shift > 0) begin
            v = v + (64'sd1 <<< (shift - 1));
        end
        v  = v >>> shift;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        sat = 1'b0;
        if (v > hi) begin
            v   = hi;
            sat = 1'b1;
        end else if (v < lo) begin
            v   = lo;
            sat = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/systolic_fir_array_pe.sv
// ----------------------------------------------------------------------------
// fir_pe
//   One processing element of the transposed-form systolic FIR chain.
//   Holds one coefficient h[k] (part of a shift chain used for loading),
//   multiplies it with the broadcast sample x, and keeps the partial sum
//   p[k] = p[k+1] + h[k]*x, updated only on accepted samples.
//
// Ports
//   clk        : rising-edge clock
//   rst        : asynchronous reset, active-low
//   en         : accepted sample this cycle, update p
//   clr        : clear p (chain clear on coefficient reload)
//   coef_shift : shift the coefficient chain by one position
//   coef_in    : coefficient from the next-higher tap (or the load port)
//   coef_out   : this tap's coefficient h[k]
//   x          : broadcast input sample
//   p_in       : partial sum from the next-higher tap p[k+1]
//   p_out      : this tap's partial sum p[k]
// ----------------------------------------------------------------------------
module fir_pe
    import fir_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int ACC_W  = 35
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     clr,
    input  logic                     coef_shift,
    input  logic signed [COEF_W-1:0] coef_in,
    output logic signed [COEF_W-1:0] coef_out,
    input  logic signed [DATA_W-1:0] x,
    input  logic signed [ACC_W-1:0]  p_in,
    output logic signed [ACC_W-1:0]  p_out
);

    logic signed [COEF_W-1:0] r_h;
    logic signed [ACC_W-1:0]  r_p;
    logic signed [ACC_W-1:0]  w_x_ext;
    logic signed [ACC_W-1:0]  w_h_ext;
    logic signed [ACC_W-1:0]  w_prod;

    // Operands are sign-extended to the accumulator width first; the exact
    // product always fits, so keeping only ACC_W bits loses nothing.
    assign w_x_ext = ACC_W'(x);
    assign w_h_ext = ACC_W'(r_h);
    assign w_prod  = w_x_ext * w_h_ext;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_h <= '0;
        end else if (coef_shift) begin
            r_h <= coef_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_p <= '0;
        end else if (clr) begin
            r_p <= '0;
        end else if (en) begin
            r_p <= p_in + w_prod;
        end
    end

    assign coef_out = r_h;
    assign p_out    = r_p;

endmodule

// File: rtl/systolic_fir_array.sv
// ----------------------------------------------------------------------------
// systolic_fir_array
//   Transposed-form FIR filter y[n] = sum h[k]*x[n-k] built from TAPS fir_pe
//   elements, followed by a round/saturate output register.
//
//   Pipeline: PE 0's partial-sum register is the accumulator stage (v1);
//   the output register (out_valid) follows it. Both stages advance when
//   adv = !out_valid || out_ready. Bubbles travel as valid=0.
//
//   Handshakes: a transfer occurs on a rising edge where valid && ready are
//   both high; valid and data are held by the sender until that edge, ready
//   may change freely. in_ready = adv && !coef_busy. out_data is stable while
//   out_valid && !out_ready.
//
//   Coefficient load: coef_start enters LOAD (chain cleared, counter reset),
//   each coef_wr shifts one word in at the top tap; the TAPS-th write
//   returns to RUN. A sample accepted on the same edge as coef_start is
//   dropped together with the chain clear.
//
// Ports
//   clk, rst              : clock, asynchronous active-low reset
//   in_valid/in_ready     : sample handshake, in_data signed DATA_W
//   coef_start, coef_wr   : begin load, coefficient strobe
//   coef_data             : signed COEF_W coefficient word
//   coef_busy             : high while in LOAD
//   out_valid/out_ready   : output handshake, out_data signed OUT_W
//   sat_flag              : sticky, set by any saturated output, cleared by
//                           reset or coef_start
//   dbg_state             : current FSM state
// ----------------------------------------------------------------------------
module systolic_fir_array
    import fir_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int TAPS   = 8,
    parameter int SHIFT  = 15,
    parameter int OUT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     coef_start,
    input  logic                     coef_wr,
    input  logic signed [COEF_W-1:0] coef_data,
    output logic                     coef_busy,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  out_data,
    output logic                     sat_flag,
    output fir_state_t               dbg_state
);

    localparam int ACC_W = acc_width(DATA_W, COEF_W, TAPS);
    localparam int CNT_W = $clog2(TAPS + 1);

    // ------------------------------------------------------------------
    // Load FSM
    // ------------------------------------------------------------------
    fir_state_t       r_state;
    fir_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_wr_cnt;
    logic [CNT_W-1:0] w_wr_cnt_nxt;
    logic             w_coef_shift;
    logic             w_chain_clr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_RUN;
            r_wr_cnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_wr_cnt <= w_wr_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_wr_cnt_nxt = r_wr_cnt;
        w_coef_shift = 1'b0;
        w_chain_clr  = 1'b0;
        case (r_state)
            ST_RUN: begin
                // coef_wr is ignored here.
                if (coef_start) begin
                    w_state_nxt  = ST_LOAD;
                    w_wr_cnt_nxt = '0;
                    w_chain_clr  = 1'b1;
                end
            end
            ST_LOAD: begin
                // A restart keeps the partially shifted coefficients; only
                // the count starts over. A coinciding coef_wr is not taken.
                if (coef_start) begin
                    w_wr_cnt_nxt = '0;
                    w_chain_clr  = 1'b1;
                end else if (coef_wr) begin
                    w_coef_shift = 1'b1;
                    if (r_wr_cnt == CNT_W'(TAPS - 1)) begin
                        w_state_nxt  = ST_RUN;
                        w_wr_cnt_nxt = '0;
                    end else begin
                        w_wr_cnt_nxt = r_wr_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt  = ST_RUN;
                w_wr_cnt_nxt = '0;
            end
        endcase
    end

    assign coef_busy = (r_state == ST_LOAD);
    assign dbg_state = r_state;

    // ------------------------------------------------------------------
    // Flow control
    // ------------------------------------------------------------------
    logic r_v1;
    logic r_out_valid;
    logic w_adv;
    logic w_accept;
    logic w_take;

    assign w_adv    = !r_out_valid || out_ready;
    assign in_ready = w_adv && !coef_busy;
    assign w_accept = in_valid && in_ready;
    // coef_start wins over a coinciding accepted sample: it is discarded.
    assign w_take   = w_accept && !coef_start;

    // ------------------------------------------------------------------
    // Systolic chain: w_p[k] = p[k]; w_p[0] is the accumulator.
    // w_h[k] = h[k]; w_h[TAPS] is the load port feeding the top tap.
    // ------------------------------------------------------------------
    logic signed [ACC_W-1:0]  w_p [0:TAPS];
    logic signed [COEF_W-1:0] w_h [0:TAPS];

    assign w_p[TAPS] = '0;
    assign w_h[TAPS] = coef_data;

    genvar k;
    generate
        for (k = 0; k < TAPS; k++) begin : g_pe
            // Tap 0's register is the accumulator stage, which must keep
            // draining across a reload, so it is never chain-cleared.
            fir_pe #(
                .DATA_W (DATA_W),
                .COEF_W (COEF_W),
                .ACC_W  (ACC_W)
            ) u_pe (
                .clk        (clk),
                .rst        (rst),
                .en         (w_take),
                .clr        ((k == 0) ? 1'b0 : w_chain_clr),
                .coef_shift (w_coef_shift),
                .coef_in    (w_h[k+1]),
                .coef_out   (w_h[k]),
                .x          (in_data),
                .p_in       (w_p[k+1]),
                .p_out      (w_p[k])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_v1 <= 1'b0;
        end else if (w_adv) begin
            r_v1 <= w_take;
        end
    end

    // ------------------------------------------------------------------
    // Output stage: round, shift, saturate
    // ------------------------------------------------------------------
    logic signed [RS_W-1:0]  w_rs;
    logic                    w_sat;
    logic signed [OUT_W-1:0] r_out_data;
    logic                    r_sat_flag;

    always_comb begin
        w_sat = 1'b0;
        w_rs  = round_sat(RS_W'(w_p[0]), SHIFT, OUT_W, w_sat);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_adv) begin
            r_out_valid <= r_v1;
            if (r_v1) begin
                r_out_data <= OUT_W'(w_rs);
            end
        end
    end

    // A saturated result entering the output register on the same edge as
    // coef_start is still reported.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sat_flag <= 1'b0;
        end else if (w_adv && r_v1 && w_sat) begin
            r_sat_flag <= 1'b1;
        end else if (coef_start) begin
            r_sat_flag <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign sat_flag  = r_sat_flag;

endmodule

// File: tb/tb_systolic_fir_array.sv
// ----------------------------------------------------------------------------
// tb_systolic_fir_array
//   Two DUT instances (SHIFT=0 and SHIFT=1, TAPS=4, 16-bit everywhere) share
//   all inputs. A direct-form reference model (sample history x sum of
//   coefficient products) produces the expected output for each accepted
//   sample; a monitor compares whenever out_valid is presented.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_systolic_fir_array;
  import fir_pkg::*;

  localparam int TAPS = 4;
  localparam int W    = 16;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // shared inputs
  logic                in_valid   = 1'b0;
  logic signed [W-1:0] in_data    = '0;
  logic                coef_start = 1'b0;
  logic                coef_wr    = 1'b0;
  logic signed [W-1:0] coef_data  = '0;
  logic                out_ready  = 1'b1;

  // per-instance outputs
  logic                in_ready0, in_ready1;
  logic                coef_busy0, coef_busy1;
  logic                out_valid0, out_valid1;
  logic signed [W-1:0] out_data0, out_data1;
  logic                sat_flag0, sat_flag1;
  fir_state_t          dbg_state0, dbg_state1;

  systolic_fir_array #(.DATA_W(W), .COEF_W(W), .TAPS(TAPS), .SHIFT(0), .OUT_W(W)) u_dut0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .coef_start(coef_start), .coef_wr(coef_wr), .coef_data(coef_data), .coef_busy(coef_busy0),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0), .sat_flag(sat_flag0),
    .dbg_state(dbg_state0)
  );

  systolic_fir_array #(.DATA_W(W), .COEF_W(W), .TAPS(TAPS), .SHIFT(1), .OUT_W(W)) u_dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .coef_start(coef_start), .coef_wr(coef_wr), .coef_data(coef_data), .coef_busy(coef_busy1),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1), .sat_flag(sat_flag1),
    .dbg_state(dbg_state1)
  );

  // bookkeeping
  int errors = 0;
  int checks = 0;
  int cyc_n  = 0;
  bit lat_on = 1'b0;
  always @(negedge clk) cyc_n++;

  // reference model state
  longint h_m [TAPS];
  longint x_m [TAPS];   // x_m[0] newest accepted sample
  bit     busy_m = 1'b0;
  int     wcnt_m = 0;

  // scoreboard
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  int           exp_cyc[$];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint ref_y();
    longint s = 0;
    for (int k = 0; k < TAPS; k++) s += h_m[k] * x_m[k];
    return s;
  endfunction

  // round half up, arithmetic shift, clamp to 16-bit signed
  function automatic logic [W-1:0] ref_out(input longint acc, input int shift);
    longint v = acc;
    if (shift > 0) v += (longint'(1) << (shift - 1));
    v = v >>> shift;
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    return v[W-1:0];
  endfunction

  task automatic model_clear();
    for (int k = 0; k < TAPS; k++) begin
      h_m[k] = 0;
      x_m[k] = 0;
    end
    busy_m = 1'b0;
    wcnt_m = 0;
    exp_q0.delete();
    exp_q1.delete();
    exp_cyc.delete();
  endtask

  // driver: one clock cycle of stimulus, model updated from the handshake
  task automatic cyc(input bit vld, input int data, input bit ordy,
                     input bit cst, input bit cwr, input int cdat);
    bit     acc;
    longint y;
    @(negedge clk);
    in_valid   = vld;
    in_data    = W'(data);
    out_ready  = ordy;
    coef_start = cst;
    coef_wr    = cwr;
    coef_data  = W'(cdat);
    #1;
    chk("coef_busy0", coef_busy0, busy_m);
    chk("coef_busy1", coef_busy1, busy_m);
    chk("dbg_state0", (dbg_state0 == ST_LOAD), busy_m);
    chk("dbg_state1", (dbg_state1 == ST_LOAD), busy_m);
    if (busy_m) begin
      chk("in_ready0_load", in_ready0, 0);
      chk("in_ready1_load", in_ready1, 0);
    end
    if (out_valid0 && !out_ready) chk("in_ready0_stall", in_ready0, 0);
    acc = in_valid && in_ready0;
    if (cst) begin
      for (int k = 0; k < TAPS; k++) x_m[k] = 0;
      busy_m = 1'b1;
      wcnt_m = 0;
    end else begin
      if (acc) begin
        for (int k = TAPS - 1; k > 0; k--) x_m[k] = x_m[k-1];
        x_m[0] = data;
        y = ref_y();
        exp_q0.push_back(ref_out(y, 0));
        exp_q1.push_back(ref_out(y, 1));
        exp_cyc.push_back(cyc_n);
      end
      if (cwr && busy_m) begin
        for (int k = 0; k < TAPS - 1; k++) h_m[k] = h_m[k+1];
        h_m[TAPS-1] = cdat;
        wcnt_m++;
        if (wcnt_m == TAPS) busy_m = 1'b0;
      end
    end
  endtask

  function automatic int rnd16();
    return int'($urandom_range(65535)) - 32768;
  endfunction

  task automatic load4(input int c0, input int c1, input int c2, input int c3, input bit rnd);
    int c[TAPS];
    c[0] = c0; c[1] = c1; c[2] = c2; c[3] = c3;
    cyc(rnd ? ($urandom_range(1) == 1) : 1'b0, rnd16(), rnd ? ($urandom_range(3) != 0) : 1'b1, 1'b1, 1'b0, 0);
    for (int i = 0; i < TAPS; i++)
      cyc(rnd ? ($urandom_range(1) == 1) : 1'b0, rnd16(), rnd ? ($urandom_range(3) != 0) : 1'b1, 1'b0, 1'b1, c[i]);
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (exp_q0.size() == 0 && !out_valid0) break;
      cyc(1'b0, 0, 1'b1, 1'b0, 1'b0, 0);
    end
    chk("drain_queue_empty", exp_q0.size(), 0);
  endtask

  task automatic reset_checks();
    chk("rst_out_valid0", out_valid0, 0);
    chk("rst_out_valid1", out_valid1, 0);
    chk("rst_out_data0", out_data0, 0);
    chk("rst_sat_flag0", sat_flag0, 0);
    chk("rst_coef_busy0", coef_busy0, 0);
    chk("rst_coef_busy1", coef_busy1, 0);
    chk("rst_state0_run", (dbg_state0 == ST_RUN), 1);
  endtask

  // asynchronous reset in the middle of the low clock phase
  task automatic mid_reset();
    #2;
    rst        = 1'b0;
    in_valid   = 1'b0;
    coef_start = 1'b0;
    coef_wr    = 1'b0;
    out_ready  = 1'b1;
    model_clear();
    #1;
    reset_checks();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // monitor: compare whatever the DUT presents against the queue head
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst && out_valid0) begin
        if (exp_q0.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output0: actual out_valid=1 data=%0d required out_valid=0", out_data0);
        end else begin
          chk("out_data0", out_data0, longint'($signed(exp_q0[0])));
          chk("out_data1", out_data1, longint'($signed(exp_q1[0])));
          chk("out_valid1", out_valid1, 1);
          if (lat_on) chk("latency", cyc_n - exp_cyc[0], 2);
          if (out_ready) begin
            void'(exp_q0.pop_front());
            void'(exp_q1.pop_front());
            void'(exp_cyc.pop_front());
          end
        end
      end else if (rst && out_valid1) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output1: actual out_valid=1 required out_valid=0");
      end
    end
  end

  initial begin
    int xs [5];
    model_clear();
    // reset
    repeat (3) @(negedge clk);
    reset_checks();
    rst = 1'b1;

    // impulse
    load4(1, 2, 3, 4, 1'b0);
    lat_on = 1'b1;
    xs = '{1, 0, 0, 0, 0};
    foreach (xs[i]) cyc(1'b1, xs[i], 1'b1, 1'b0, 1'b0, 0);
    drain();
    lat_on = 1'b0;

    // step
    load4(22, 22, 22, 22, 1'b0);
    lat_on = 1'b1;
    repeat (8) cyc(1'b1, -150, 1'b1, 1'b0, 1'b0, 0);
    drain();
    lat_on = 1'b0;
    chk("step_sat_flag0", sat_flag0, 0);
    chk("step_sat_flag1", sat_flag1, 0);

    // saturation
    load4(32767, 32767, 32767, 32767, 1'b0);
    repeat (6) cyc(1'b1, 32767, 1'b1, 1'b0, 1'b0, 0);
    repeat (6) cyc(1'b1, -32768, 1'b1, 1'b0, 1'b0, 0);
    drain();
    repeat (3) cyc(1'b0, 0, 1'b1, 1'b0, 1'b0, 0);
    chk("sat_flag0_sticky", sat_flag0, 1);
    chk("sat_flag1_sticky", sat_flag1, 1);

    // rounding, coefficient load by hand so sat_flag clear can be observed
    cyc(1'b0, 0, 1'b1, 1'b1, 1'b0, 0);
    cyc(1'b0, 0, 1'b1, 1'b0, 1'b1, 1);
    chk("sat_flag0_cleared", sat_flag0, 0);
    chk("sat_flag1_cleared", sat_flag1, 0);
    for (int i = 0; i < TAPS - 1; i++) cyc(1'b0, 0, 1'b1, 1'b0, 1'b1, 0);
    cyc(1'b1, 3, 1'b1, 1'b0, 1'b0, 0);
    cyc(1'b1, -3, 1'b1, 1'b0, 1'b0, 0);
    cyc(1'b1, -2, 1'b1, 1'b0, 1'b0, 0);
    drain();

    // backpressure: continuous in_valid, out_ready low for 3 cycles
    load4(3, -1, 2, 5, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 100 + i, 1'b1, 1'b0, 1'b0, 0);
    for (int i = 0; i < 3; i++) cyc(1'b1, -200 - i, 1'b0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 300 + i, 1'b1, 1'b0, 1'b0, 0);
    drain();

    // reset after 2 of 4 writes
    cyc(1'b0, 0, 1'b1, 1'b1, 1'b0, 0);
    cyc(1'b0, 0, 1'b1, 1'b0, 1'b1, 7);
    cyc(1'b0, 0, 1'b1, 1'b0, 1'b1, 8);
    mid_reset();
    chk("post_rst_coef_busy0", coef_busy0, 0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1000 + i, 1'b1, 1'b0, 1'b0, 0);
    drain();
    // coef_start + coef_wr + in_valid together: sample dropped
    cyc(1'b1, 77, 1'b1, 1'b1, 1'b1, 9);
    for (int i = 0; i < TAPS; i++) cyc(1'b1, 78, 1'b1, 1'b0, 1'b1, 10 * (i + 1));
    for (int i = 0; i < 4; i++) cyc(1'b1, -5 * i + 1, 1'b1, 1'b0, 1'b0, 0);
    drain();

    // randomized traffic with occasional reloads and backpressure
    load4(rnd16(), rnd16(), rnd16(), rnd16(), 1'b1);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(63) == 0)
        load4(rnd16(), rnd16(), rnd16(), rnd16(), 1'b1);
      else
        cyc($urandom_range(3) != 0, rnd16(), $urandom_range(3) != 0, 1'b0, 1'b0, 0);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/systolic_fir_array.md
SYSTOLIC_FIR_ARRAY -- requirements
Module: systolic_fir_array

Interface
REQ-001 SHALL have parameter DATA_W, default 16, sample width (signed).
REQ-002 SHALL have parameter COEF_W, default 16, coefficient width (signed).
REQ-003 SHALL have parameter TAPS, default 8, tap count (>=2).
REQ-004 SHALL have parameter SHIFT, default 15, right-shift applied to the accumulator before output.
REQ-005 SHALL have parameter OUT_W, default 16, output width (signed).
REQ-006 SHALL use one clock and asynchronous active-low reset: clk input 1, rising-edge clock; rst input 1, asynchronous reset, active-low.
REQ-007 Sample input ports: in_valid input 1; in_ready output 1; in_data input DATA_W, signed sample.
REQ-008 Coefficient input ports: coef_start input 1, begins a load; coef_wr input 1, coefficient strobe; coef_data input COEF_W; coef_busy output 1, high while loading.
REQ-009 Output ports: out_valid output 1; out_ready input 1; out_data output OUT_W, signed; sat_flag output 1, sticky saturation indicator.

Function
REQ-010 SHALL implement transposed-form FIR y[n] = sum h[k]*x[n-k], k=0..TAPS-1, with a systolic partial-sum chain p[1..TAPS-1].
REQ-011 Accumulator width ACC_W SHALL equal DATA_W+COEF_W+clog2(TAPS); all arithmetic SHALL be full-precision signed, with no internal overflow.
REQ-012 On an accepted sample (in_valid && in_ready), the following SHALL update on the same edge: p[k] <= p[k+1] + h[k]*x for k<TAPS-1; p[TAPS-1] <= h[TAPS-1]*x; acc <= h[0]*x + p[1].
REQ-013 The partial-sum chain SHALL NOT change on cycles without an accepted sample.
REQ-014 Output stage SHALL compute (acc + 2^(SHIFT-1)) >>> SHIFT (round half up; no rounding term when SHIFT=0), then saturate to OUT_W.
REQ-015 Pipeline SHALL be two stages: acc register (v1), then output register (out_valid). Latency SHALL be 2 clock edges from acceptance to out_valid when not stalled.
REQ-016 Signal adv SHALL equal !out_valid || out_ready. Both stages SHALL load only when adv=1, and bubbles SHALL propagate as valid=0.
REQ-017 in_ready SHALL equal adv && !coef_busy.
REQ-018 out_data SHALL hold stable while out_valid && !out_ready.
REQ-019 sat_flag SHALL set on any saturated output and clear only on reset or coef_start.
REQ-020 FSM states SHALL be RUN and LOAD.
REQ-021 RUN->LOAD SHALL occur on coef_start. On entry to LOAD: coef_busy=1, p[] cleared, write counter cleared. Samples already in acc/out stages SHALL drain normally.
REQ-022 In LOAD, each coef_wr SHALL shift: h[k] <= h[k+1] for k<TAPS-1, h[TAPS-1] <= coef_data. After TAPS writes, the first-written word SHALL reside in h[0].
REQ-023 LOAD->RUN SHALL occur on the edge registering the TAPS-th coef_wr; coef_busy SHALL fall on the following cycle.
REQ-024 coef_wr in RUN SHALL be ignored. coef_start in LOAD SHALL restart the count, with coefficients partially shifted.
REQ-025 If coef_start and an accepted sample coincide, coef_start SHALL win: in_ready is already low through REQ-017 on the following cycle, and the sample SHALL be discarded along with the chain clear.

Reset
REQ-026 While rst=0, the following SHALL hold: h[], p[] and acc = 0; v1=0; out_valid=0; out_data=0; sat_flag=0; state=RUN; coef_busy=0.
REQ-027 Reset asserted mid-LOAD or mid-stall SHALL discard all state, with no partial output.

Structure
REQ-028 Package fir_pkg SHALL hold the FSM state enum (RUN, LOAD), the clog2-based ACC_W function and the round/saturate function.
REQ-029 One sub-module fir_pe SHALL be instantiated TAPS times. It holds h[k], its multiply, and its p[k] register, with ports clk, rst, en, coef shift-in/out, x, p_in and p_out.

Verification
REQ-030 Impulse: TAPS=4, SHIFT=0, load 1,2,3,4, then feed x=1,0,0,0,0 -> out_data 1,2,3,4,0, each 2 edges after acceptance.
REQ-031 Step: TAPS=4, SHIFT=0, h=22 for all taps, x=-150 held -> outputs -3300, -6600, -9900, -13200, then steady -13200, sat_flag=0.
REQ-032 Saturation: TAPS=4, SHIFT=0, OUT_W=16, h=32767 for all taps, x=32767 -> out_data=32767 and sat_flag=1 until the next coef_start. With x=-32768 -> out_data=-32768.
REQ-033 Rounding: SHIFT=1, h=(1,0,0,0). x=3 -> out_data=2; x=-3 -> out_data=-1; x=-2 -> out_data=-1.
REQ-034 Backpressure: out_ready=0 for 3 cycles with continuous in_valid -> in_ready=0 after out_valid rises, out_data held constant, no sample lost or duplicated after out_ready returns.
REQ-035 Reset/load corner: rst low after 2 of 4 coef_wr -> coef_busy=0 and h all 0. A fresh coef_start and coef_wr coinciding with in_valid -> sample dropped, in_ready=0 until TAPS writes complete.
